// File: rtl/midi_note_tx.sv
// midi_note_tx: queues MIDI note on/off events in a small FIFO and serialises
// each one as a three-byte channel message (status, key, velocity) towards a
// byte-wide UART with a valid/ready handshake. A one-cycle all_off_req flushes
// the queue and sends All Notes Off (0xBn 0x7B 0x00) after the message in flight.
//
// Optional build macro: MIDI_RUNNING_STATUS_EN -- when defined, a status byte
// equal to the last one transmitted is suppressed (MIDI running status).
module midi_note_tx #(
    parameter int CHANNEL    = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic               data_clk,
    input  logic               reset_reg_N,
    input  logic               ev_valid,
    output logic               ev_ready,
    input  logic               ev_note_on,
    input  logic [6:0]         ev_key,
    input  logic [6:0]         ev_vel,
    input  logic               all_off_req,
    output logic [7:0]         tx_byte,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_level
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STATUS = 2'd1,
        ST_DATA1  = 2'd2,
        ST_DATA2  = 2'd3
    } state_t;

    localparam logic [3:0]       CH_NIB  = CHANNEL[3:0];
    localparam logic [FIFO_AW:0] DEPTH_L = FIFO_DEPTH[FIFO_AW:0];
    localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0] PTR_ZERO = {(FIFO_AW+1){1'b0}};

    // Builds a channel-voice status byte from its message-type nibble.
    function automatic logic [7:0] status_byte(input logic [3:0] kind);
        return {kind, CH_NIB};
    endfunction

    // FIFO storage: {note_on, key[6:0], vel[6:0]}
    logic [14:0]      mem_r [FIFO_DEPTH];
    logic [FIFO_AW:0] wr_ptr_r;
    logic [FIFO_AW:0] rd_ptr_r;
    logic [FIFO_AW:0] level_s;
    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic [14:0]      head_s;

    // Message sequencing
    state_t           state_r;
    logic [7:0]       tx_byte_r;
    logic             tx_valid_r;
    logic [7:0]       data1_r;
    logic [7:0]       data2_r;
    logic             pending_r;
    logic             rdy_en_r;
    logic             load_s;
    logic             skip_s;
    logic [7:0]       new_status_s;
    logic [7:0]       new_d1_s;
    logic [7:0]       new_d2_s;

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0]       last_status_r;
    assign skip_s = (new_status_s == last_status_r);
`else
    assign skip_s = 1'b0;
`endif

    assign level_s    = wr_ptr_r - rd_ptr_r;
    assign empty_s    = (level_s == PTR_ZERO);
    assign full_s     = (level_s == DEPTH_L);
    assign head_s     = mem_r[rd_ptr_r[FIFO_AW-1:0]];

    // rdy_en_r keeps ev_ready low while in reset and until the first edge after it.
    assign ev_ready   = rdy_en_r && !full_s && !all_off_req;
    assign push_s     = ev_valid && ev_ready;

    assign tx_byte    = tx_byte_r;
    assign tx_valid   = tx_valid_r;
    assign fifo_level = level_s;
    assign busy       = (state_r != ST_IDLE) || !empty_s || pending_r;

    // Chooses the next message when idle: pending All Notes Off first, else FIFO head.
    // A fresh all_off_req blocks the pop so the flushed events are never sent.
    always_comb begin
        load_s       = 1'b0;
        pop_s        = 1'b0;
        new_status_s = 8'h00;
        new_d1_s     = 8'h00;
        new_d2_s     = 8'h00;
        if (state_r == ST_IDLE) begin
            if (pending_r) begin
                load_s       = 1'b1;
                new_status_s = status_byte(4'hB);
                new_d1_s     = 8'h7B;
                new_d2_s     = 8'h00;
            end else if (!all_off_req && !empty_s) begin
                load_s       = 1'b1;
                pop_s        = 1'b1;
                new_status_s = head_s[14] ? status_byte(4'h9) : status_byte(4'h8);
                new_d1_s     = {1'b0, head_s[13:7]};
                new_d2_s     = {1'b0, head_s[6:0]};
            end else begin
                load_s       = 1'b0;
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // Event storage; contents need no reset because the pointers gate every read.
    always_ff @(posedge data_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[FIFO_AW-1:0]] <= {ev_note_on, ev_key, ev_vel};
        end
    end

    // FIFO pointers: all_off_req flushes the queue on the same edge.
    always_ff @(posedge data_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else if (all_off_req) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Input-ready enable: rises on the first edge after reset release.
    always_ff @(posedge data_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            rdy_en_r <= 1'b0;
        end else begin
            rdy_en_r <= 1'b1;
        end
    end

    // Message FSM with registered UART outputs and the All Notes Off pending flag.
    always_ff @(posedge data_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_r       <= ST_IDLE;
            tx_byte_r     <= 8'h00;
            tx_valid_r    <= 1'b0;
            data1_r       <= 8'h00;
            data2_r       <= 8'h00;
            pending_r     <= 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
            last_status_r <= 8'h00;
`endif
        end else begin
            if (all_off_req) begin
                pending_r <= 1'b1;
            end else if ((state_r == ST_IDLE) && pending_r) begin
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (load_s) begin
                        data1_r    <= new_d1_s;
                        data2_r    <= new_d2_s;
                        tx_valid_r <= 1'b1;
                        if (skip_s) begin
                            tx_byte_r <= new_d1_s;
                            state_r   <= ST_DATA1;
                        end else begin
                            tx_byte_r <= new_status_s;
                            state_r   <= ST_STATUS;
                        end
                    end else begin
                        tx_valid_r <= 1'b0;
                        tx_byte_r  <= 8'h00;
                    end
                end
                ST_STATUS: begin
                    if (tx_ready) begin
`ifdef MIDI_RUNNING_STATUS_EN
                        last_status_r <= tx_byte_r;
`endif
                        tx_byte_r <= data1_r;
                        state_r   <= ST_DATA1;
                    end else begin
                        state_r   <= ST_STATUS;
                    end
                end
                ST_DATA1: begin
                    if (tx_ready) begin
                        tx_byte_r <= data2_r;
                        state_r   <= ST_DATA2;
                    end else begin
                        state_r   <= ST_DATA1;
                    end
                end
                ST_DATA2: begin
                    if (tx_ready) begin
                        tx_byte_r  <= 8'h00;
                        tx_valid_r <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        state_r    <= ST_DATA2;
                    end
                end
                default: begin
                    tx_byte_r  <= 8'h00;
                    tx_valid_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_midi_note_tx.sv
// Directed bench for midi_note_tx (CHANNEL 0, FIFO_DEPTH 4). Expected byte
// streams are written out by hand; the ones that depend on the running-status
// build option are selected with the same macro.
module tb_midi_note_tx;

    logic       data_clk;
    logic       reset_reg_N;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_note_on;
    logic [6:0] ev_key;
    logic [6:0] ev_vel;
    logic       all_off_req;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic [2:0] fifo_level;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [7:0] got   [$];
    int         got_t [$];
    logic [7:0] exp_q [$];

    midi_note_tx #(.CHANNEL(0), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .data_clk    (data_clk),
        .reset_reg_N (reset_reg_N),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_note_on  (ev_note_on),
        .ev_key      (ev_key),
        .ev_vel      (ev_vel),
        .all_off_req (all_off_req),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .fifo_level  (fifo_level)
    );

    initial data_clk = 1'b0;
    always #5 data_clk = ~data_clk;

    // Records every accepted UART byte and the cycle it was taken.
    always @(posedge data_clk) begin
        cyc <= cyc + 1;
        if (tx_valid && tx_ready) begin
            got.push_back(tx_byte);
            got_t.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_seq(input string tag, input logic [7:0] e [$]);
        chk({tag, "_len"}, got.size(), e.size());
        for (int i = 0; i < e.size(); i++) begin
            chk(tag, (i < got.size()) ? {24'h0, got[i]} : 32'hDEAD_BEEF, {24'h0, e[i]});
        end
    endtask

    task automatic step();
        @(posedge data_clk);
        #1;
    endtask

    task automatic push(input logic on, input logic [6:0] k, input logic [6:0] v);
        ev_valid   = 1'b1;
        ev_note_on = on;
        ev_key     = k;
        ev_vel     = v;
        step();
        ev_valid   = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            step();
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        reset_reg_N = 1'b1;
        ev_valid    = 1'b0;
        ev_note_on  = 1'b0;
        ev_key      = 7'd0;
        ev_vel      = 7'd0;
        all_off_req = 1'b0;
        tx_ready    = 1'b1;
        #1 reset_reg_N = 1'b0;
        #2;
        // Reset state
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_level", fifo_level, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ev_ready", ev_ready, 1'b0);
        step();
        step();
        reset_reg_N = 1'b1;
        chk("rel_ev_ready_before_edge", ev_ready, 1'b0);
        step();
        chk("rel_ev_ready_first_edge", ev_ready, 1'b1);

        // Basic note on, key 60 vel 100, tx_ready high
        got.delete(); got_t.delete();
        push(1'b1, 7'd60, 7'd100);
        chk("lat_level_after_accept", fifo_level, 3'd1);
        chk("lat_valid_k", tx_valid, 1'b0);
        step();
        chk("lat_valid_k1", tx_valid, 1'b1);
        chk("lat_status", tx_byte, 8'h90);
        step();
        chk("lat_key", tx_byte, 8'h3C);
        step();
        chk("lat_vel", tx_byte, 8'h64);
        step();
        chk("lat_done_valid", tx_valid, 1'b0);
        chk("lat_done_busy", busy, 1'b0);

        // Stall in DATA1 for 5 cycles; note off key 60 vel 64
        got.delete(); got_t.delete();
        push(1'b0, 7'd60, 7'd64);
        step();
        chk("stall_status", tx_byte, 8'h80);
        step();
        chk("stall_d1", tx_byte, 8'h3C);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_hold_byte", tx_byte, 8'h3C);
            chk("stall_hold_valid", tx_valid, 1'b1);
        end
        tx_ready = 1'b1;
        step();
        chk("stall_d2", tx_byte, 8'h40);
        step();
        chk("stall_end_valid", tx_valid, 1'b0);
        exp_q = '{8'h80, 8'h3C, 8'h40};
        chk_seq("stall_seq", exp_q);

        // FIFO full with tx stalled: first event moves into the FSM, four stay queued
        got.delete(); got_t.delete();
        tx_ready = 1'b0;
        push(1'b1, 7'd10, 7'd20);
        push(1'b0, 7'd11, 7'd21);
        push(1'b1, 7'd12, 7'd22);
        push(1'b0, 7'd13, 7'd23);
        push(1'b1, 7'd14, 7'd24);
        chk("full_level", fifo_level, 3'd4);
        chk("full_ev_ready", ev_ready, 1'b0);
        chk("full_head_byte", tx_byte, 8'h90);
        tx_ready = 1'b1;
        wait_idle(100);
        exp_q = '{8'h90, 8'h0A, 8'h14, 8'h80, 8'h0B, 8'h15, 8'h90, 8'h0C, 8'h16,
                  8'h80, 8'h0D, 8'h17, 8'h90, 8'h0E, 8'h18};
        chk_seq("full_seq", exp_q);
        chk("full_level_end", fifo_level, 3'd0);

        // All Notes Off mid-message with three events queued, colliding with ev_valid
        got.delete(); got_t.delete();
        tx_ready = 1'b0;
        push(1'b1, 7'h30, 7'h31);
        push(1'b1, 7'h32, 7'h33);
        push(1'b0, 7'h34, 7'h35);
        push(1'b1, 7'h36, 7'h37);
        chk("ao_level_before", fifo_level, 3'd3);
        all_off_req = 1'b1;
        ev_valid    = 1'b1;
        ev_note_on  = 1'b1;
        ev_key      = 7'h60;
        ev_vel      = 7'h61;
        #1;
        chk("ao_ev_ready_low", ev_ready, 1'b0);
        step();
        all_off_req = 1'b0;
        ev_valid    = 1'b0;
        chk("ao_level_flushed", fifo_level, 3'd0);
        chk("ao_busy", busy, 1'b1);
        tx_ready = 1'b1;
        wait_idle(100);
`ifdef MIDI_RUNNING_STATUS_EN
        exp_q = '{8'h30, 8'h31, 8'hB0, 8'h7B, 8'h00};
`else
        exp_q = '{8'h90, 8'h30, 8'h31, 8'hB0, 8'h7B, 8'h00};
`endif
        chk_seq("ao_seq", exp_q);

        // Two back-to-back note ons: running status and one idle cycle between messages
        got.delete(); got_t.delete();
        push(1'b1, 7'h40, 7'h41);
        push(1'b1, 7'h42, 7'h43);
        wait_idle(100);
`ifdef MIDI_RUNNING_STATUS_EN
        exp_q = '{8'h90, 8'h40, 8'h41, 8'h42, 8'h43};
`else
        exp_q = '{8'h90, 8'h40, 8'h41, 8'h90, 8'h42, 8'h43};
`endif
        chk_seq("b2b_seq", exp_q);
        chk("b2b_gap", (got_t.size() > 3) ? (got_t[3] - got_t[2]) : -1, 2);

        // Reset in DATA1, then note on with velocity 0 must resend its status
        push(1'b1, 7'h50, 7'h51);
        for (int i = 0; i < 10; i++) begin
            if (!(tx_valid && tx_byte == 8'h50)) begin
                step();
            end
        end
        chk("rst_mid_reach_d1", tx_byte, 8'h50);
        reset_reg_N = 1'b0;
        #1;
        chk("rst_mid_tx_valid", tx_valid, 1'b0);
        chk("rst_mid_tx_byte", tx_byte, 8'h00);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_ev_ready", ev_ready, 1'b0);
        got.delete(); got_t.delete();
        step();
        reset_reg_N = 1'b1;
        step();
        chk("rst_mid_ev_ready_rel", ev_ready, 1'b1);
        push(1'b1, 7'h52, 7'h00);
        wait_idle(100);
        exp_q = '{8'h90, 8'h52, 8'h00};
        chk_seq("post_rst_seq", exp_q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
